// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and its baud counter.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } tx_state_t;

  function automatic int baud_cnt_width(input int clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable down-counter that strobes o_tick on the last cycle of each bit period.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= RELOAD;
    end else if (i_en) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the byte FIFO and serialises them as 8N1 (or 8E1) UART frames.
// state  | meaning
// IDLE   | line idle, wait for tx_en and a non-empty FIFO
// FETCH  | one-cycle read strobe, note whether the read can be lost
// LOAD   | retry a lost read, else capture the byte
// START  | start bit
// DATA   | eight data bits, LSB first
// PARITY | even parity bit (only when enabled)
// STOP   | stop bit(s)
// DONE   | one-cycle completion pulse
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic                 fifo_empty,
  input  logic                 fifo_wr,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  tx_state_t              r_state, w_state_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic [BIT_IDX_W-1:0]   r_bit_idx, w_bit_idx_next;
  logic                   r_lost, r_parity;
  logic                   r_tx, r_fifo_rd, r_busy, r_tx_done;
  logic                   w_tx_next, w_busy_next;
  logic                   w_tick, w_baud_load, w_baud_en;

  assign w_baud_load = (r_state == S_LOAD) && !r_lost;
  assign w_baud_en   = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_baud_load),
    .i_en   (w_baud_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = 1'b1;
    w_busy_next    = 1'b0;
    case (r_state)
      S_IDLE:  if (tx_en && !fifo_empty) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_LOAD;
      S_LOAD: begin
        if (r_lost) begin
          w_state_next = S_FETCH;
        end else begin
          w_shift_next   = fifo_data;
          w_bit_idx_next = '0;
          w_state_next   = S_START;
        end
      end
      S_START: if (w_tick) w_state_next = S_DATA;
      S_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == BIT_IDX_W'(DATA_BITS - 1)) begin
            w_bit_idx_next = '0;
            w_state_next   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
            w_shift_next   = r_shift >> 1;
          end
        end
      end
      S_PARITY: if (w_tick) w_state_next = S_STOP;
      S_STOP: begin
        if (w_tick) begin
          if (r_bit_idx == BIT_IDX_W'(STOP_BITS - 1)) begin
            w_bit_idx_next = '0;
            w_state_next   = S_DONE;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
      S_PARITY: w_tx_next = r_parity;
      default:  w_tx_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != S_IDLE) && (w_state_next != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_lost    <= 1'b0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_fifo_rd <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_idx <= w_bit_idx_next;
      // A write or an empty FIFO during the strobe means the FIFO ignored it.
      if (r_state == S_FETCH) r_lost <= fifo_wr | fifo_empty;
      if (w_baud_load) r_parity <= ^fifo_data;
      r_tx      <= w_tx_next;
      r_fifo_rd <= (w_state_next == S_FETCH);
      r_busy    <= w_busy_next;
      r_tx_done <= (w_state_next == S_DONE);
    end
  end

  assign fifo_rd = r_fifo_rd;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: 8N1 and 8E1 instances behind a small FIFO model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en0 = 1'b0;
  logic       tx_en1 = 1'b0;
  logic       fifo_wr = 1'b0;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_empty;
  logic       rd0, tx0, busy0, done0;
  logic       rd1, tx1, busy1, done1;
  logic       sel = 1'b0;

  logic [7:0] q_mem [0:31];
  int         q_rd = 0;
  int         q_wr = 0;
  int         rd_pulses = 0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic mon_tx, mon_rd, mon_busy, mon_done;
  assign mon_tx   = sel ? tx1   : tx0;
  assign mon_rd   = sel ? rd1   : rd0;
  assign mon_busy = sel ? busy1 : busy0;
  assign mon_done = sel ? done1 : done0;

  assign fifo_empty = (q_rd == q_wr);

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en0), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_rd(rd0), .tx(tx0), .busy(busy0), .tx_done(done0)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_p (
    .clk(clk), .rst(rst), .tx_en(tx_en1), .fifo_empty(fifo_empty), .fifo_wr(fifo_wr),
    .fifo_data(fifo_data), .fifo_rd(rd1), .tx(tx1), .busy(busy1), .tx_done(done1)
  );

  always #5 clk = ~clk;

  // FIFO model: write has priority, data appears the cycle after an honoured read.
  always @(posedge clk) begin
    if (rd0 | rd1) rd_pulses <= rd_pulses + 1;
    if ((rd0 | rd1) && !fifo_empty && !fifo_wr) begin
      fifo_data <= q_mem[q_rd];
      q_rd      <= q_rd + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [7:0] b);
    q_mem[q_wr] = b;
    q_wr++;
  endtask

  // Entered at the LOAD-cycle sample point; leaves at the IDLE cycle after DONE.
  task automatic check_frame(input string tag, input logic [7:0] b, input bit par_en,
                             input logic exp_par, output int start_cyc, output int done_cyc);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) start_cyc = cyc;
      check($sformatf("%s_start", tag), mon_tx, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("%s_bit%0d", tag, i), mon_tx, b[i]);
        if (k == 0) begin
          check($sformatf("%s_busy%0d", tag, i), mon_busy, 1'b1);
          check($sformatf("%s_rd%0d", tag, i), mon_rd, 1'b0);
        end
      end
    end
    if (par_en) begin
      for (int k = 0; k < 4; k++) begin
        step();
        check($sformatf("%s_parity", tag), mon_tx, exp_par);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("%s_stop", tag), mon_tx, 1'b1);
      check($sformatf("%s_stop_done", tag), mon_done, 1'b0);
    end
    step();
    done_cyc = cyc;
    check($sformatf("%s_done", tag), mon_done, 1'b1);
    check($sformatf("%s_done_busy", tag), mon_busy, 1'b0);
    check($sformatf("%s_done_tx", tag), mon_tx, 1'b1);
    step();
    check($sformatf("%s_done_pulse", tag), mon_done, 1'b0);
    check($sformatf("%s_idle_tx", tag), mon_tx, 1'b1);
  endtask

  initial begin
    int s0, d0, s1, d1, rd_base;

    // Reset held with a byte waiting: nothing may move.
    tx_en0 = 1'b1;
    push(8'hA5);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_tx", tx0, 1'b1);
      check("rst_rd", rd0, 1'b0);
      check("rst_busy", busy0, 1'b0);
      check("rst_done", done0, 1'b0);
    end
    check("rst_no_read", rd_pulses, 0);

    // Single byte 0xA5: release marks cycle 0.
    rst = 1'b1;
    cyc = 0;
    step();
    check("a5_rd_c1", rd0, 1'b1);
    check("a5_busy_c1", busy0, 1'b1);
    step();
    check("a5_rd_c2", rd0, 1'b0);
    check("a5_tx_c2", tx0, 1'b1);
    check_frame("a5", 8'hA5, 1'b0, 1'b0, s0, d0);
    check("a5_start_cyc", s0, 3);
    check("a5_done_cyc", d0, 43);
    check("a5_rd_count", rd_pulses, 1);

    // Lost read: a write during FETCH forces a retry two cycles later.
    rd_base = rd_pulses;
    push(8'h3C);
    step();
    check("lost_rd1", rd0, 1'b1);
    fifo_wr = 1'b1;
    step();
    fifo_wr = 1'b0;
    check("lost_load1", rd0, 1'b0);
    step();
    check("lost_rd2", rd0, 1'b1);
    step();
    check_frame("lost", 8'h3C, 1'b0, 1'b0, s0, d0);
    check("lost_rd_count", rd_pulses - rd_base, 2);

    // Back-to-back 0x00 then 0xFF.
    rd_base = rd_pulses;
    push(8'h00);
    push(8'hFF);
    step();
    check("b2b_rd1", rd0, 1'b1);
    step();
    check_frame("b2b0", 8'h00, 1'b0, 1'b0, s0, d0);
    check("b2b_idle_rd", rd0, 1'b0);
    step();
    check("b2b_rd2", rd0, 1'b1);
    check("b2b_fetch_tx", tx0, 1'b1);
    step();
    check("b2b_load_tx", tx0, 1'b1);
    check_frame("b2bf", 8'hFF, 1'b0, 1'b0, s1, d1);
    // DONE, IDLE, FETCH, LOAD between the first frame and the second start bit.
    check("b2b_gap", s1 - d0, 4);
    check("b2b_rd_count", rd_pulses - rd_base, 2);

    // tx_en low holds the line idle despite a waiting byte.
    tx_en0 = 1'b0;
    rd_base = rd_pulses;
    push(8'h5A);
    for (int k = 0; k < 6; k++) step();
    check("hold_rd_count", rd_pulses - rd_base, 0);
    check("hold_busy", busy0, 1'b0);
    tx_en0 = 1'b1;
    step();
    check("hold_rd", rd0, 1'b1);
    step();

    // Reset in the middle of bit 3 of 0x5A.
    for (int k = 0; k < 4 + 12 + 2; k++) step();
    check("mid_bit3", tx0, 1'b1);
    check("mid_busy", busy0, 1'b1);
    push(8'h81);
    rst = 1'b0;
    step();
    check("mid_rst_tx", tx0, 1'b1);
    check("mid_rst_busy", busy0, 1'b0);
    check("mid_rst_rd", rd0, 1'b0);
    check("mid_rst_done", done0, 1'b0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_rd", rd0, 1'b1);
    tx_en0 = 1'b0;
    step();
    check_frame("post_rst", 8'h81, 1'b0, 1'b0, s0, d0);

    // Even parity instance.
    sel = 1'b1;
    tx_en1 = 1'b1;
    push(8'h07);
    step();
    check("par07_rd", rd1, 1'b1);
    step();
    check_frame("par07", 8'h07, 1'b1, 1'b1, s0, d0);
    check("par07_len", d0 - s0, 44);
    push(8'h03);
    step();
    check("par03_rd", rd1, 1'b1);
    step();
    check_frame("par03", 8'h03, 1'b1, 1'b0, s0, d0);
    check("par03_len", d0 - s0, 44);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
